// File: rtl/seq_mult_pkg.sv
// Shared definitions for the digit-serial multiplier controller.
//   P          : digit width in bits (only 2 supported)
//   MAX_DIGITS : maximum digits per operand
//   SEL_W      : digit-select width
//   K_W        : column-index width (columns 0..2*MAX_DIGITS-2, plus final digit tag)
//   ctrl_state_e : controller states
//   col_first  : first pair index i of column k for an N-digit operand
`timescale 1ns/1ps
package seq_mult_pkg;

    localparam int P          = 2;
    localparam int MAX_WIDTH  = 16;
    localparam int MAX_DIGITS = MAX_WIDTH / P;
    localparam int SEL_W      = $clog2(MAX_DIGITS);
    localparam int K_W        = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        LAST = 2'd2
    } ctrl_state_e;

    // First i of column k is max(0, k-N+1) = max(0, k-n_m1).
    function automatic logic [SEL_W-1:0] col_first(input logic [K_W-1:0]   k,
                                                   input logic [SEL_W-1:0] n_m1);
        logic [K_W-1:0] diff;
        diff = k - {1'b0, n_m1};
        return (k > {1'b0, n_m1}) ? diff[SEL_W-1:0] : '0;
    endfunction

endpackage

// File: rtl/seq_mult_pair_cnt.sv
// Column-wise (product-scanning) pair counter.
// Walks the pairs (i, j = k-i) of column k with i ascending, then moves to
// the next column.
//   clk, rst_n  : clock, async active-low reset
//   clear       : restart at column 0, pair 0
//   advance     : step to the next pair
//   n_m1        : operand digits minus one
//   i, j, k     : current pair and column
//   first_pair  : current pair is the first of its column
//   last_pair   : current pair is the last of its column
//   last_col    : current column is 2N-2
`timescale 1ns/1ps
module seq_mult_pair_cnt
    import seq_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [SEL_W-1:0] n_m1,
    output logic [SEL_W-1:0] i,
    output logic [SEL_W-1:0] j,
    output logic [K_W-1:0]   k,
    output logic             first_pair,
    output logic             last_pair,
    output logic             last_col
);

    logic [SEL_W-1:0] i_last;
    logic [K_W-1:0]   k_next;

    always_comb begin
        // Last i of column k is min(k, N-1).
        i_last     = (k > {1'b0, n_m1}) ? n_m1 : k[SEL_W-1:0];
        k_next     = k + 1'b1;
        j          = k[SEL_W-1:0] - i;
        first_pair = (i == col_first(k, n_m1));
        last_pair  = (i == i_last);
        last_col   = (k == {n_m1, 1'b0});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            k <= '0;
        end else if (clear) begin
            i <= '0;
            k <= '0;
        end else if (advance) begin
            if (last_pair) begin
                k <= k_next;
                i <= col_first(k_next, n_m1);
            end else begin
                i <= i + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing controller for the 2-bit digit-serial multiplier datapath.
// Accepts one job over valid/ready, drives the datapath strobes for a
// product-scanning schedule (N^2 MAC cycles + one LAST cycle) and tags each
// product digit as it leaves the datapath.
//   clk, rst_n         : clock, async active-low reset
//   req_valid/ready    : request handshake; req_ndig_m1 = N-1, req_signed
//   abort              : synchronous return to IDLE, no further digits
//   busy               : job in progress
//   dig_valid, dig_idx : registered output digit tag, done on final digit
//   start .. placeOne  : datapath control strobes
//   muxSelA/B          : operand digit selects
//   countShiftInput    : carry shift-in value
//   initSum            : accumulator/carry init value (always zero)
`timescale 1ns/1ps
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_ndig_m1,
    input  logic             req_signed,
    input  logic             abort,
    output logic             busy,
    output logic             dig_valid,
    output logic [SEL_W:0]   dig_idx,
    output logic             done,
    output logic             start,
    output logic             countDown,
    output logic             countLast2,
    output logic             lastOut,
    output logic             invertFirstBit,
    output logic             invertSecondRow,
    output logic             placeOne,
    output logic [SEL_W-1:0] muxSelA,
    output logic [SEL_W-1:0] muxSelB,
    output logic [1:0]       countShiftInput,
    output logic [4*P-1:0]   initSum
);

    ctrl_state_e      state, state_nxt;
    logic [SEL_W-1:0] n_m1;
    logic             sgn;

    logic [SEL_W-1:0] pi, pj;
    logic [K_W-1:0]   pk;
    logic             first_pair, last_pair, last_col;
    logic             i_top, j_top, mid_col;

    assign initSum = '0;

    seq_mult_pair_cnt u_pair_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .advance    (state == MAC),
        .n_m1       (n_m1),
        .i          (pi),
        .j          (pj),
        .k          (pk),
        .first_pair (first_pair),
        .last_pair  (last_pair),
        .last_col   (last_col)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        busy            = 1'b0;
        start           = 1'b0;
        countDown       = 1'b0;
        countLast2      = 1'b0;
        lastOut         = 1'b0;
        invertFirstBit  = 1'b0;
        invertSecondRow = 1'b0;
        placeOne        = 1'b0;
        muxSelA         = '0;
        muxSelB         = '0;
        countShiftInput = 2'b00;
        i_top           = (pi == n_m1);
        j_top           = (pj == n_m1);
        mid_col         = (pk == {1'b0, n_m1});

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                // An abort in the same cycle blocks acceptance.
                if (req_valid && !abort) begin
                    start     = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                busy       = 1'b1;
                muxSelA    = pi;
                muxSelB    = pj;
                countLast2 = last_pair;
                countDown  = (pk > {1'b0, n_m1});
                if (sgn) begin
                    // Baugh-Wooley: sign-row partial products are inverted,
                    // the sign*sign product is not, and the correction ones
                    // enter at column N-1.
                    invertFirstBit  = i_top ^ j_top;
                    invertSecondRow = i_top & j_top;
                    placeOne        = first_pair & mid_col;
                    if (last_pair && mid_col) countShiftInput = 2'b01;
                end
                if (last_pair && last_col) state_nxt = LAST;
            end
            LAST: begin
                busy      = 1'b1;
                lastOut   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            n_m1  <= '0;
            sgn   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                n_m1 <= req_ndig_m1;
                sgn  <= req_signed;
            end
        end
    end

    // A digit leaves the datapath one cycle after its column closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_valid <= 1'b0;
            dig_idx   <= '0;
            done      <= 1'b0;
        end else begin
            dig_valid <= (countLast2 | lastOut) & ~abort;
            done      <= lastOut & ~abort;
            if (countLast2 || lastOut)
                dig_idx <= lastOut ? {n_m1, 1'b1} : pk;
        end
    end

endmodule
